// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - immediate format encodings and decode-stage occupancy/state encoding
package imm_pkg;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;
    localparam logic [2:0] IMM_Z = 3'b101;

    // State encoding doubles as the occupancy count.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

endpackage

// File: rtl/imm_extend.sv
// rtl/imm_extend.sv - combinational RISC-V immediate format decode and extension
module imm_extend
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      immsrc,
    output logic [XLEN-1:0] immext,
    output logic            illegal
);

    logic [31:0] imm32;
    logic        unused_opcode;

    assign unused_opcode = ^instr[6:0];

    always_comb begin
        imm32   = '0;
        illegal = 1'b0;
        case (immsrc)
            IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm32 = {instr[31:12], 12'b0};
            IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_Z: imm32 = {27'b0, instr[19:15]};
            default: illegal = 1'b1;
        endcase
    end

    // Bit 31 of every format already carries the right extension bit, including Z and illegal (0).
    assign immext = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - immediate decode stage with registered output and one-entry skid buffer
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int TAGW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [2:0]      immsrc,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] immext,
    output logic [TAGW-1:0] out_tag,
    output logic            illegal,
    output logic [1:0]      occupancy
);

    logic [1:0]      state;
    logic [1:0]      state_next;
    logic [XLEN-1:0] dec_imm;
    logic            dec_ill;
    logic [XLEN-1:0] skid_imm;
    logic [TAGW-1:0] skid_tag;
    logic            skid_ill;
    logic            accept;
    logic            emit;
    logic            load_out;
    logic            load_skid;
    logic            skid_to_out;

    imm_extend #(.XLEN(XLEN)) u_extend (
        .instr   (instr),
        .immsrc  (immsrc),
        .immext  (dec_imm),
        .illegal (dec_ill)
    );

    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;
    assign out_valid = (state != ST_EMPTY);
    assign occupancy = state;

    // Flush wins over everything, so it also suppresses every data register load.
    always_comb begin
        state_next  = state;
        load_out    = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        if (flush) begin
            state_next = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_next = ST_ONE;
                        load_out   = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && !emit) begin
                        state_next = ST_TWO;
                        load_skid  = 1'b1;
                    end else if (accept && emit) begin
                        load_out = 1'b1;
                    end else if (emit) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (emit) begin
                        state_next  = ST_ONE;
                        skid_to_out = 1'b1;
                    end
                end
                default: state_next = ST_EMPTY;
            endcase
        end
    end

    // in_ready is a flop so upstream never sees a combinational path from out_ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_next;
            in_ready <= (state_next != ST_TWO);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            immext  <= '0;
            out_tag <= '0;
            illegal <= 1'b0;
        end else if (load_out) begin
            immext  <= dec_imm;
            out_tag <= in_tag;
            illegal <= dec_ill;
        end else if (skid_to_out) begin
            immext  <= skid_imm;
            out_tag <= skid_tag;
            illegal <= skid_ill;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_imm <= '0;
            skid_tag <= '0;
            skid_ill <= 1'b0;
        end else if (load_skid) begin
            skid_imm <= dec_imm;
            skid_tag <= in_tag;
            skid_ill <= dec_ill;
        end
    end

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb/tb_imm_decode_stage.sv - self-checking bench for imm_decode_stage at XLEN 32 and 64
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [2:0]  immsrc;
    logic [31:0] in_tag;

    logic        rdy32, rdy64, vld32, vld64, ill32, ill64;
    logic [31:0] imm32, tag32, tag64;
    logic [63:0] imm64;
    logic [1:0]  occ32, occ64;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32), .TAGW(32)) dut32 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
        .instr(instr), .immsrc(immsrc), .in_tag(in_tag), .out_valid(vld32), .out_ready(out_ready),
        .immext(imm32), .out_tag(tag32), .illegal(ill32), .occupancy(occ32)
    );

    imm_decode_stage #(.XLEN(64), .TAGW(32)) dut64 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
        .instr(instr), .immsrc(immsrc), .in_tag(in_tag), .out_valid(vld64), .out_ready(out_ready),
        .immext(imm64), .out_tag(tag64), .illegal(ill64), .occupancy(occ64)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference immediate straight from the format table, always at 64 bits.
    function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] s);
        case (s)
            3'd0: return 64'(longint'($signed(i[31:20])));
            3'd1: return 64'(longint'($signed({i[31:25], i[11:7]})));
            3'd2: return 64'(longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})));
            3'd3: return 64'(longint'($signed({i[31:12], 12'b0})));
            3'd4: return 64'(longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})));
            3'd5: return {59'b0, i[19:15]};
            default: return 64'd0;
        endcase
    endfunction

    typedef struct packed {
        logic [63:0] imm;
        logic [31:0] tag;
        logic        ill;
    } item_t;

    item_t q[$];
    bit    fresh = 1'b1;
    bit    m_acc;
    bit    m_emit;

    // Model: a FIFO of at most two items, cleared by reset or flush.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            fresh = 1'b1;
        end else begin
            m_acc  = in_valid && (q.size() < 2);
            m_emit = (q.size() > 0) && out_ready;
            if (m_acc) fresh = 1'b0;
            if (flush) begin
                q.delete();
            end else begin
                if (m_emit) void'(q.pop_front());
                if (m_acc) q.push_back('{imm: ref_imm(instr, immsrc), tag: in_tag, ill: (immsrc >= 3'd6)});
            end
        end
    end

    always @(negedge clk) begin
        check("occ32", 64'(occ32), 64'(q.size()));
        check("occ64", 64'(occ64), 64'(q.size()));
        check("rdy32", 64'(rdy32), 64'(q.size() < 2));
        check("rdy64", 64'(rdy64), 64'(q.size() < 2));
        check("vld32", 64'(vld32), 64'(q.size() != 0));
        check("vld64", 64'(vld64), 64'(q.size() != 0));
        if (q.size() != 0) begin
            check("imm32", 64'(imm32), 64'(q[0].imm[31:0]));
            check("imm64", imm64, q[0].imm);
            check("tag32", 64'(tag32), 64'(q[0].tag));
            check("tag64", 64'(tag64), 64'(q[0].tag));
            check("ill32", 64'(ill32), 64'(q[0].ill));
            check("ill64", 64'(ill64), 64'(q[0].ill));
        end else if (fresh) begin
            check("rst_imm64", imm64, 64'd0);
            check("rst_tag32", 64'(tag32), 64'd0);
            check("rst_ill32", 64'(ill32), 64'd0);
        end
    end

    task automatic offer(input logic [31:0] i, input logic [2:0] s, input logic [31:0] t);
        instr    = i;
        immsrc   = s;
        in_tag   = t;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    logic [31:0] v_instr [9] = '{32'hFFF00093, 32'h12345037, 32'hFFDFF06F, 32'h800F8073,
                                 32'hFE112E23, 32'hFE000EE3, 32'h800F8073, 32'h800F8073, 32'h80000037};
    logic [2:0]  v_src   [9] = '{3'd0, 3'd3, 3'd4, 3'd5, 3'd1, 3'd2, 3'd7, 3'd6, 3'd3};
    logic [63:0] v_exp   [9] = '{64'hFFFFFFFFFFFFFFFF, 64'h0000000012345000, 64'hFFFFFFFFFFFFFFFC,
                                 64'h000000000000001F, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC,
                                 64'h0, 64'h0, 64'hFFFFFFFF80000000};

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; immsrc = '0; in_tag = '0;
        repeat (2) @(negedge clk);
        check("reset_rdy", 64'(rdy32), 64'd1);
        check("reset_vld", 64'(vld64), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed formats, one-cycle latency, back-to-back with out_ready high.
        out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            offer(v_instr[k], v_src[k], 32'(k + 100));
            check("lit_vld", 64'(vld32), 64'd1);
            check("lit_imm64", imm64, v_exp[k]);
            check("lit_imm32", 64'(imm32), 64'(v_exp[k][31:0]));
            check("lit_ill", 64'(ill64), 64'(v_src[k] >= 3'd6));
        end
        repeat (2) @(negedge clk);

        // Backpressure: tags 1,2,3 with the sink stalled, then released.
        out_ready = 1'b0;
        instr = 32'h00500093; immsrc = 3'd0;
        in_valid = 1'b1; in_tag = 32'd1; @(negedge clk);
        in_tag = 32'd2; @(negedge clk);
        in_tag = 32'd3; @(negedge clk);
        check("bp_occ", 64'(occ32), 64'd2);
        check("bp_rdy", 64'(rdy32), 64'd0);
        check("bp_tag1", 64'(tag32), 64'd1);
        @(negedge clk);
        check("bp_hold", 64'(tag64), 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_tag2", 64'(tag32), 64'd2);
        @(negedge clk);
        check("bp_tag3", 64'(tag32), 64'd3);
        check("bp_vld3", 64'(vld32), 64'd1);
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_drain", 64'(vld32), 64'd0);

        // Flush while full with an item offered.
        out_ready = 1'b0;
        in_valid = 1'b1; in_tag = 32'd10; @(negedge clk);
        in_tag = 32'd11; @(negedge clk);
        in_tag = 32'd12; flush = 1'b1; @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("fl_occ", 64'(occ64), 64'd0);
        check("fl_vld", 64'(vld64), 64'd0);
        check("fl_rdy", 64'(rdy64), 64'd1);
        out_ready = 1'b1;
        offer(32'hFFF00093, 3'd0, 32'd13);
        check("fl_next", 64'(tag32), 64'd13);
        @(negedge clk);

        // Flush in ONE together with an accept: the accepted item is discarded.
        out_ready = 1'b0;
        in_valid = 1'b1; in_tag = 32'd20; @(negedge clk);
        in_tag = 32'd21; flush = 1'b1; @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("fla_occ", 64'(occ32), 64'd0);
        @(negedge clk);
        check("fla_gone", 64'(vld32), 64'd0);

        // Asynchronous reset pulse mid-stream.
        in_valid = 1'b1; in_tag = 32'd40; @(negedge clk);
        in_tag = 32'd41; @(negedge clk);
        in_tag = 32'd42;
        #2 reset = 1'b1;
        #1;
        check("ar_occ", 64'(occ64), 64'd0);
        check("ar_vld", 64'(vld32), 64'd0);
        check("ar_rdy", 64'(rdy32), 64'd1);
        check("ar_imm", imm64, 64'd0);
        check("ar_tag", 64'(tag32), 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        offer(32'hFFDFF06F, 3'd4, 32'd50);
        check("ar_first_tag", 64'(tag64), 64'd50);
        check("ar_first_imm", imm64, 64'hFFFFFFFFFFFFFFFC);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 Parameter XLEN, default 32: immediate output width; legal values 32 and 64.
REQ-002 Parameter TAGW, default 32: width of the sideband tag (typically PC) carried alongside each immediate.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  synchronous pipeline flush.
REQ-006 in_valid  input  1  upstream item valid.
REQ-007 in_ready  output  1  stage can accept.
REQ-008 instr  input  32  instruction word; bits [6:0] are ignored.
REQ-009 immsrc  input  3  immediate format select.
REQ-010 in_tag  input  TAGW  sideband tag.
REQ-011 out_valid  output  1  output item valid.
REQ-012 out_ready  input  1  downstream accepts.
REQ-013 immext  output  XLEN  extended immediate.
REQ-014 out_tag  output  TAGW  tag matching immext.
REQ-015 illegal  output  1  immsrc was an unsupported encoding.
REQ-016 occupancy  output  2  items held: 0, 1 or 2.

Function
REQ-017 Format encodings:
- 000 I: sext(instr[31:20]).
- 001 S: sext({instr[31:25],instr[11:7]}).
- 010 B: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
- 011 U: sext({instr[31:12],12'b0}).
- 100 J: sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
- 101 Z: zero-extended instr[19:15] (CSR uimm).
REQ-018 Sign extension replicates instr[31] up to bit XLEN-1; U-type is also sign-extended above bit 31 when XLEN=64.
REQ-019 immsrc 110/111 produce immext=0 and illegal=1; all legal encodings produce illegal=0.
REQ-020 Transfers: accept = in_valid & in_ready; emit = out_valid & out_ready.
REQ-021 Output is registered: the first accepted item appears on out_valid/immext/out_tag/illegal the cycle after accept, with latency exactly 1 when empty.
REQ-022 Buffer states:
- EMPTY: occupancy 0.
- ONE: output register full.
- TWO: output and skid registers full.
REQ-023 Transitions:
- EMPTY + accept -> ONE.
- ONE + accept & ~emit -> TWO (item into skid).
- ONE + accept & emit -> ONE (output register reloaded).
- ONE + ~accept & emit -> EMPTY.
- TWO + emit -> ONE (skid moves to output).
- Otherwise hold.
REQ-024 in_ready is registered, equals ~(state==TWO), and never depends combinationally on out_ready.
REQ-025 Items leave in acceptance order; none is dropped or duplicated; immext, out_tag and illegal stay stable while out_valid=1 and out_ready=0.
REQ-026 out_valid=1 in states ONE and TWO; occupancy encodes the state.
REQ-027 flush=1 forces EMPTY next cycle and discards any item accepted in the same cycle; in_ready=1 next cycle; flush has priority over all transitions.
REQ-028 Data registers load only on accept or on skid transfer; their contents in EMPTY are don't-care but outputs read 0 after reset.

Reset
REQ-029 Reset asserted: state EMPTY, in_ready=1, out_valid=0, occupancy=0, immext=0, out_tag=0, illegal=0, applied asynchronously.
REQ-030 Reset asserted mid-transfer discards all held items; the first accept after deassertion behaves as from EMPTY.

Structure
REQ-031 Package imm_pkg holds the immsrc encoding constants (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z) and the occupancy/state encoding.
REQ-032 Combinational format decode is one sub-module, imm_extend, parametrised by XLEN, outputting immext and illegal; it is instantiated once, at the input side, ahead of the registers.

Verification
REQ-033 XLEN=32, instr=0xFFF00093, immsrc=000 -> next cycle out_valid=1, immext=0xFFFFFFFF, illegal=0.
REQ-034 XLEN=64: instr=0x12345037, immsrc=011 -> immext=0x0000000012345000; instr=0xFFDFF06F, immsrc=100 -> immext=0xFFFFFFFFFFFFFFFC.
REQ-035 immsrc=101 with instr[19:15]=11111 and instr[31]=1 -> immext=0x1F; immsrc=111 -> immext=0, illegal=1.
REQ-036 Backpressure:
- Stimulus: out_ready=0, three back-to-back items with tags 1, 2, 3.
- Response: tags 1 and 2 accepted, then in_ready=0 and occupancy=2.
- Then raise out_ready: tags emerge in the order 1, 2, 3 with no bubbles.
REQ-037 Flush with occupancy=2 while in_valid=1 -> next cycle occupancy=0, out_valid=0, in_ready=1, and the flushed item never appears; asynchronous reset pulse mid-stream gives the same result.
